// File: rtl/time_counters.sv
// time_counters: BCD seconds/minutes/hours chain with run-mode carries and set-mode per-stage advance.
module time_counters #(
  parameter int HOUR_MAX = 23
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Tick,
  input  logic       i_Inc_Pulse,
  input  logic       i_Counters_Reset,
  input  logic       i_Counters_Enable_Increment,
  input  logic [2:0] i_Counters_Enable_Count,
  output logic [7:0] o_Sec_BCD,
  output logic [7:0] o_Min_BCD,
  output logic [7:0] o_Hour_BCD,
  output logic       o_Day_Wrap
);
  localparam logic [7:0] HMAX_BCD = 8'((HOUR_MAX / 10) * 16 + (HOUR_MAX % 10));
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] m);
    return (v == m) ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  logic [7:0] r_sec, r_min, r_hour;
  logic       r_day_wrap;
  logic       w_run, w_sec_inc, w_sec_carry, w_min_inc, w_min_carry, w_hour_inc, w_day_wrap;
  // Carries exist only in run mode and die at a disabled stage; a seconds clear kills the seconds carry.
  always_comb begin
    w_run       = ~i_Counters_Enable_Increment;
    w_sec_inc   = i_Counters_Enable_Count[0] & (w_run ? i_Tick : i_Inc_Pulse);
    w_sec_carry = w_run & w_sec_inc & (r_sec == 8'h59) & ~i_Counters_Reset;
    w_min_inc   = i_Counters_Enable_Count[1] & (w_run ? w_sec_carry : i_Inc_Pulse);
    w_min_carry = w_run & w_min_inc & (r_min == 8'h59);
    w_hour_inc  = i_Counters_Enable_Count[2] & (w_run ? w_min_carry : i_Inc_Pulse);
    w_day_wrap  = w_run & w_hour_inc & (r_hour == HMAX_BCD);
  end
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_sec      <= 8'h00;
      r_min      <= 8'h00;
      r_hour     <= 8'h00;
      r_day_wrap <= 1'b0;
    end else begin
      r_sec      <= i_Counters_Reset ? 8'h00 : w_sec_inc ? bcd_inc(r_sec, 8'h59) : r_sec;
      r_min      <= w_min_inc ? bcd_inc(r_min, 8'h59) : r_min;
      r_hour     <= w_hour_inc ? bcd_inc(r_hour, HMAX_BCD) : r_hour;
      r_day_wrap <= w_day_wrap;
    end
  end
  assign o_Sec_BCD  = r_sec;
  assign o_Min_BCD  = r_min;
  assign o_Hour_BCD = r_hour;
  assign o_Day_Wrap = r_day_wrap;
endmodule

// File: tb/tb_time_counters.sv
// tb_time_counters: random and directed stimulus against an integer time-of-day model.
module tb_time_counters;
  localparam int HM = 23;
  logic       i_Clock = 1'b0;
  logic       i_Reset_n = 1'b0;
  logic       i_Tick = 1'b0, i_Inc_Pulse = 1'b0, i_Counters_Reset = 1'b0, i_Counters_Enable_Increment = 1'b0;
  logic [2:0] i_Counters_Enable_Count = 3'b000;
  logic [7:0] o_Sec_BCD, o_Min_BCD, o_Hour_BCD;
  logic       o_Day_Wrap;
  int checks = 0, failures = 0;
  int m_s = 0, m_m = 0, m_h = 0, m_w = 0;
  time_counters #(.HOUR_MAX(HM)) dut (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Tick(i_Tick), .i_Inc_Pulse(i_Inc_Pulse),
    .i_Counters_Reset(i_Counters_Reset), .i_Counters_Enable_Increment(i_Counters_Enable_Increment),
    .i_Counters_Enable_Count(i_Counters_Enable_Count), .o_Sec_BCD(o_Sec_BCD), .o_Min_BCD(o_Min_BCD),
    .o_Hour_BCD(o_Hour_BCD), .o_Day_Wrap(o_Day_Wrap)
  );
  always #5 i_Clock = ~i_Clock;
  function automatic logic [31:0] bcd(input int v);
    return 32'((v / 10) * 16 + (v % 10));
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic check_outs(input string tag);
    chk({tag, ".sec"}, 32'(o_Sec_BCD), bcd(m_s));
    chk({tag, ".min"}, 32'(o_Min_BCD), bcd(m_m));
    chk({tag, ".hour"}, 32'(o_Hour_BCD), bcd(m_h));
    chk({tag, ".wrap"}, 32'(o_Day_Wrap), 32'(m_w));
  endtask
  // Reference: seconds-level rules of the clock, not the DUT's structure.
  task automatic model(input bit tk, ic, cl, md, input bit [2:0] en);
    bit cs, cm, hi;
    m_w = 0;
    if (!md) begin
      cs = tk && en[0] && m_s == 59 && !cl;
      if (tk && en[0]) m_s = (m_s + 1) % 60;
      cm = cs && en[1] && m_m == 59;
      if (cs && en[1]) m_m = (m_m + 1) % 60;
      hi = cm && en[2];
      if (hi) begin
        m_w = (m_h == HM) ? 1 : 0;
        m_h = (m_h + 1) % (HM + 1);
      end
    end else if (ic) begin
      if (en[0]) m_s = (m_s + 1) % 60;
      if (en[1]) m_m = (m_m + 1) % 60;
      if (en[2]) m_h = (m_h + 1) % (HM + 1);
    end
    if (cl) m_s = 0;
  endtask
  task automatic step(input string tag, input bit tk, ic, cl, md, input bit [2:0] en);
    i_Tick = tk; i_Inc_Pulse = ic; i_Counters_Reset = cl;
    i_Counters_Enable_Increment = md; i_Counters_Enable_Count = en;
    @(posedge i_Clock);
    model(tk, ic, cl, md, en);
    #1;
    check_outs(tag);
  endtask
  task automatic do_reset();
    i_Tick = 0; i_Inc_Pulse = 0; i_Counters_Reset = 0;
    i_Reset_n = 0;
    m_s = 0; m_m = 0; m_h = 0; m_w = 0;
    #1;
    check_outs("async_rst");
    #2 i_Reset_n = 1;
  endtask
  task automatic preset(input int h, m, s);
    do_reset();
    for (int k = 0; k < h; k++) step("pre_h", 0, 1, 0, 1, 3'b100);
    for (int k = 0; k < m; k++) step("pre_m", 0, 1, 0, 1, 3'b010);
    for (int k = 0; k < s; k++) step("pre_s", 0, 1, 0, 1, 3'b001);
  endtask
  initial begin
    #2;
    check_outs("por");
    #2 i_Reset_n = 1;
    @(posedge i_Clock); #1;
    preset(12, 34, 56);
    chk("pre_1234", {8'h0, o_Hour_BCD, o_Min_BCD, o_Sec_BCD}, 32'h123456);
    do_reset();
    step("rst_tick", 1, 0, 0, 0, 3'b111);
    chk("rst_tick_t", {8'h0, o_Hour_BCD, o_Min_BCD, o_Sec_BCD}, 32'h000001);
    preset(23, 59, 58);
    step("day1", 1, 0, 0, 0, 3'b111);
    step("day2", 1, 0, 0, 0, 3'b111);
    chk("day_t", {7'h0, o_Day_Wrap, o_Hour_BCD, o_Min_BCD, o_Sec_BCD}, 32'h01000000);
    step("day3", 0, 0, 0, 0, 3'b111);
    chk("day_wrap_off", 32'(o_Day_Wrap), 32'h0);
    preset(10, 59, 30);
    step("setmin", 0, 1, 0, 1, 3'b010);
    chk("setmin_t", {8'h0, o_Hour_BCD, o_Min_BCD, o_Sec_BCD}, 32'h100030);
    for (int k = 0; k < 5; k++) begin
      step("set_tick", 1, 0, 0, 1, 3'b010);
      step("set_gap", 0, 0, 0, 1, 3'b010);
    end
    chk("set_freeze", 32'(o_Sec_BCD), 32'h30);
    preset(3, 7, 45);
    step("clr45", 1, 0, 1, 0, 3'b111);
    chk("clr45_t", {8'h0, o_Hour_BCD, o_Min_BCD, o_Sec_BCD}, 32'h030700);
    preset(3, 7, 59);
    step("clr59", 1, 0, 1, 0, 3'b111);
    chk("clr59_t", {8'h0, o_Hour_BCD, o_Min_BCD, o_Sec_BCD}, 32'h030700);
    preset(5, 17, 59);
    step("broken", 1, 0, 0, 0, 3'b001);
    chk("broken_t", {8'h0, o_Hour_BCD, o_Min_BCD, o_Sec_BCD}, 32'h051700);
    preset(8, 20, 33);
    step("cu_idle", 0, 0, 0, 0, 3'b111);
    step("cu_clr", 0, 0, 1, 0, 3'b111);
    step("cu_min", 0, 1, 0, 1, 3'b010);
    step("cu_hour", 0, 1, 0, 1, 3'b100);
    chk("cu_set_t", {8'h0, o_Hour_BCD, o_Min_BCD, o_Sec_BCD}, 32'h092100);
    step("cu_run", 1, 0, 0, 0, 3'b111);
    chk("cu_run_t", {8'h0, o_Hour_BCD, o_Min_BCD, o_Sec_BCD}, 32'h092101);
    for (int n = 0; n < 4000; n++) begin
      bit md;
      bit [2:0] en;
      if (n % 500 == 0) preset(HM, 59, 50 + int'($urandom_range(0, 9)));
      md = ($urandom_range(0, 5) == 0);
      en = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      step("rand", 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0), md, en);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
